// File: rtl/gate_sweep_ctrl_v_if.sv
// Host/gate-side bundle of gate_sweep_ctrl_v: sweep request, function select,
// gate feedback, stimulus vector and sweep results.
interface gate_sweep_ctrl_v_if #(
    parameter int N_IN = 4
);
    logic            i_start;
    logic [2:0]      i_func;
    logic            i_dut_f;
    logic [N_IN-1:0] o_vec;
    logic            o_busy;
    logic            o_done;
    logic            o_pass;
    logic [N_IN:0]   o_err_cnt;
    logic [N_IN-1:0] o_fail_vec;

    modport master (
        output i_start, i_func, i_dut_f,
        input  o_vec, o_busy, o_done, o_pass, o_err_cnt, o_fail_vec
    );

    modport slave (
        input  i_start, i_func, i_dut_f,
        output o_vec, o_busy, o_done, o_pass, o_err_cnt, o_fail_vec
    );
endinterface

// File: rtl/gate_sweep_ctrl_v.sv
// Exhaustive sweep controller for an N_IN-input gate: drives every input vector,
// checks the gate against a reference function. Option: SWEEP_STOP_ON_FAIL_EN.
module gate_sweep_ctrl_v #(
    parameter int N_IN  = 4,
    parameter int DWELL = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    gate_sweep_ctrl_v_if.slave bus
);
    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;
    logic            first_fail_q, first_fail_d;
    logic [2:0]      func_q, func_d;

    logic ref_f;
    logic sample;
    logic mismatch;

    // Reference is a reduction over the whole vector, optionally inverted.
    always_comb begin
        ref_f = 1'b0;
        case (func_q)
            3'd0:    ref_f = &vec_q;
            3'd1:    ref_f = ~&vec_q;
            3'd2:    ref_f = |vec_q;
            3'd3:    ref_f = ~|vec_q;
            3'd4:    ref_f = ^vec_q;
            3'd5:    ref_f = ~^vec_q;
            default: ref_f = 1'b0;
        endcase
    end

    assign sample   = (state_q == DRIVE) && (dwell_q == DWELL_LAST);
    assign mismatch = (bus.i_dut_f != ref_f);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        dwell_d      = dwell_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        first_fail_d = first_fail_q;
        func_d       = func_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d      = DRIVE;
                    func_d       = bus.i_func;
                    err_cnt_d    = '0;
                    fail_vec_d   = '0;
                    first_fail_d = 1'b0;
                    vec_d        = '0;
                    dwell_d      = '0;
                end
            end
            DRIVE: begin
                if (!sample) begin
                    dwell_d = dwell_q + DW'(1);
                end else begin
                    dwell_d = '0;
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + (N_IN+1)'(1);
                        if (!first_fail_q) begin
                            fail_vec_d   = vec_q;
                            first_fail_d = 1'b1;
                        end
                    end
`ifdef SWEEP_STOP_ON_FAIL_EN
                    // Stop leaves vec_q frozen on the failing vector.
                    if (mismatch || (vec_q == VEC_LAST)) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
`else
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            dwell_q      <= '0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            first_fail_q <= 1'b0;
            func_q       <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            dwell_q      <= dwell_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            first_fail_q <= first_fail_d;
            func_q       <= func_d;
        end
    end

    assign bus.o_vec      = vec_q;
    assign bus.o_busy     = (state_q == DRIVE);
    assign bus.o_done     = (state_q == DONE);
    assign bus.o_pass     = (state_q == DONE) && (err_cnt_q == '0);
    assign bus.o_err_cnt  = err_cnt_q;
    assign bus.o_fail_vec = fail_vec_q;
endmodule

// File: tb/tb_gate_sweep_ctrl_v.sv
// Bench for gate_sweep_ctrl_v: a 4-input/dwell-4 instance driving a selectable
// gate model, plus a 1-input/dwell-1 instance for back-to-back restarts.
module tb_gate_sweep_ctrl_v;
    localparam int NV    = 16;
    localparam int DWL   = 4;
    localparam int LIMIT = 2000;

    logic clk;
    logic rst_n;
    int   gate_sel;
    bit   g1_inv;
    int   n_checks;
    int   n_fail;

    gate_sweep_ctrl_v_if #(.N_IN(4)) bus ();
    gate_sweep_ctrl_v_if #(.N_IN(1)) bus1 ();

    gate_sweep_ctrl_v #(.N_IN(4), .DWELL(DWL)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    gate_sweep_ctrl_v #(.N_IN(1), .DWELL(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gate function from the count of ones: 0 AND,1 NAND,2 OR,3 NOR,4 XOR,5 XNOR,6 const0
    function automatic bit model_ref(int f, int v, int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += (v >> i) & 1;
        case (f)
            0:       return ones == n;
            1:       return ones != n;
            2:       return ones > 0;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Gate under test: types 0..6 as above, 7 = output stuck at 1
    function automatic bit gate_out(int g, int v);
        if (g == 7) return 1'b1;
        return model_ref(g, v, 4);
    endfunction

    assign bus.i_dut_f  = gate_out(gate_sel, int'(bus.o_vec));
    assign bus1.i_dut_f = g1_inv ? ~bus1.o_vec[0] : bus1.o_vec[0];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_sweep(input int func, input int gate,
                               output int e_err, output int e_fail,
                               output int e_busy, output int e_last);
        e_err  = 0;
        e_fail = 0;
        e_busy = 0;
        e_last = NV - 1;
        for (int v = 0; v < NV; v++) begin
            e_busy += DWL;
            if (model_ref(func, v, 4) != gate_out(gate, v)) begin
                if (e_err == 0) e_fail = v;
                e_err++;
`ifdef SWEEP_STOP_ON_FAIL_EN
                e_last = v;
                break;
`endif
            end
        end
    endtask

    task automatic run_sweep(input string tag, input int func, input int gate, input int rp,
                             input int e_err, input int e_fail, input int e_busy, input int e_last);
        int c;
        int verr;
        @(negedge clk);
        bus.i_func  = 3'(func);
        gate_sel    = gate;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check({tag, "_start_done_low"}, int'(bus.o_done), 0);
        check({tag, "_start_err_clear"}, int'(bus.o_err_cnt), 0);
        c    = 0;
        verr = 0;
        while (bus.o_busy && c < LIMIT) begin
            if (int'(bus.o_vec) != c / DWL) verr++;
            c++;
            bus.i_start = (c == rp);
            if (c == rp) bus.i_func = 3'd4;
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        if (c >= LIMIT) check({tag, "_timeout"}, 1, 0);
        check({tag, "_busy_len"}, c, e_busy);
        check({tag, "_vec_seq"}, verr, 0);
        check({tag, "_done"}, int'(bus.o_done), 1);
        check({tag, "_pass"}, int'(bus.o_pass), (e_err == 0) ? 1 : 0);
        check({tag, "_err_cnt"}, int'(bus.o_err_cnt), e_err);
        check({tag, "_fail_vec"}, int'(bus.o_fail_vec), e_fail);
        check({tag, "_last_vec"}, int'(bus.o_vec), e_last);
        $display("sweep %s func=%0d gate=%0d busy=%0d err=%0d fail_vec=%0d pass=%0d",
                 tag, func, gate, c, bus.o_err_cnt, bus.o_fail_vec, bus.o_pass);
    endtask

    typedef struct {
        string tag;
        int    func;
        int    gate;
        int    err;
        int    fail;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int e_err, e_fail, e_busy, e_last;
        int f, g, c;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        gate_sel    = 1;
        g1_inv      = 1'b1;
        bus.i_start = 1'b0;
        bus.i_func  = 3'd0;
        bus1.i_start = 1'b0;
        bus1.i_func  = 3'd5;

        // Hand-derived full-sweep results: {tag, func, gate, mismatches, first failing vector}
        tbl[0] = '{"nand_ok",      1, 1, 0,  0};
        tbl[1] = '{"nand_vs_and",  1, 0, 16, 0};
        tbl[2] = '{"and_stuck1",   0, 7, 15, 0};
        tbl[3] = '{"or_vs_xor",    2, 4, 7,  3};
        tbl[4] = '{"nor_ok",       3, 3, 0,  0};
        tbl[5] = '{"xor_vs_xnor",  4, 5, 16, 0};
        tbl[6] = '{"const0_ok",    6, 6, 0,  0};
        tbl[7] = '{"xnor_stuck1",  5, 7, 8,  1};

        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_pass", int'(bus.o_pass), 0);
        check("rst_vec", int'(bus.o_vec), 0);
        check("rst_err", int'(bus.o_err_cnt), 0);
        check("rst_fail", int'(bus.o_fail_vec), 0);
        check("rst_done1", int'(bus1.o_done), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
`ifdef SWEEP_STOP_ON_FAIL_EN
            run_sweep(tbl[i].tag, tbl[i].func, tbl[i].gate, -1,
                      (tbl[i].err != 0) ? 1 : 0, tbl[i].fail,
                      (tbl[i].err != 0) ? (tbl[i].fail + 1) * DWL : NV * DWL,
                      (tbl[i].err != 0) ? tbl[i].fail : NV - 1);
`else
            run_sweep(tbl[i].tag, tbl[i].func, tbl[i].gate, -1,
                      tbl[i].err, tbl[i].fail, NV * DWL, NV - 1);
`endif
        end

        // Restart pulse plus function change mid-sweep must be ignored
        run_sweep("repulse", 1, 1, 10, 0, 0, NV * DWL, NV - 1);

        // Asynchronous reset in the middle of a failing sweep
        @(negedge clk);
        bus.i_func  = 3'd1;
        gate_sel    = 0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(bus.o_busy), 0);
        check("midrst_vec", int'(bus.o_vec), 0);
        check("midrst_done", int'(bus.o_done), 0);
        check("midrst_err", int'(bus.o_err_cnt), 0);
        check("midrst_fail", int'(bus.o_fail_vec), 0);
        $display("reset asserted mid-sweep busy=%0d err=%0d", bus.o_busy, bus.o_err_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("after_rst", 1, 1, -1, 0, 0, NV * DWL, NV - 1);

        // Randomised sweeps against the model
        for (int i = 0; i < 12; i++) begin
            f = int'($urandom_range(0, 7));
            g = int'($urandom_range(0, 7));
            model_sweep(f, g, e_err, e_fail, e_busy, e_last);
            run_sweep($sformatf("rand%0d", i), f, g, -1, e_err, e_fail, e_busy, e_last);
        end

        // 1-input, dwell-1 instance: back-to-back starts from DONE
        for (int it = 0; it < 4; it++) begin
            g1_inv = (it != 2);
            @(negedge clk);
            bus1.i_func  = 3'd5;
            bus1.i_start = 1'b1;
            @(negedge clk);
            bus1.i_start = 1'b0;
            check($sformatf("n1_%0d_done_drop", it), int'(bus1.o_done), 0);
            check($sformatf("n1_%0d_busy_rise", it), int'(bus1.o_busy), 1);
            c = 0;
            while (bus1.o_busy && c < LIMIT) begin
                c++;
                @(negedge clk);
            end
            if (c >= LIMIT) check("n1_timeout", 1, 0);
`ifdef SWEEP_STOP_ON_FAIL_EN
            check($sformatf("n1_%0d_busy_len", it), c, g1_inv ? 2 : 1);
            check($sformatf("n1_%0d_err", it), int'(bus1.o_err_cnt), g1_inv ? 0 : 1);
            check($sformatf("n1_%0d_last_vec", it), int'(bus1.o_vec), g1_inv ? 1 : 0);
`else
            check($sformatf("n1_%0d_busy_len", it), c, 2);
            check($sformatf("n1_%0d_err", it), int'(bus1.o_err_cnt), g1_inv ? 0 : 2);
            check($sformatf("n1_%0d_last_vec", it), int'(bus1.o_vec), 1);
`endif
            check($sformatf("n1_%0d_done", it), int'(bus1.o_done), 1);
            check($sformatf("n1_%0d_pass", it), int'(bus1.o_pass), g1_inv ? 1 : 0);
            check($sformatf("n1_%0d_fail_vec", it), int'(bus1.o_fail_vec), 0);
            $display("sweep n1_%0d inv=%0d busy=%0d err=%0d pass=%0d",
                     it, g1_inv, c, bus1.o_err_cnt, bus1.o_pass);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
